// File: rtl/mcycle_cpu_if.sv
// Instruction-memory fetch port: the core is master and raises req, memory answers with ack/rdata.
interface mcycle_cpu_if #(
  parameter int unsigned PC_W = 8
) ();
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/mcycle_cpu.sv
// Multi-cycle 4-register CPU: FETCH -> DECODE -> EXEC, with flags, conditional branch and HALT.
module mcycle_cpu #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset,
  mcycle_cpu_if.master        imem,
  output logic [PC_W-1:0]     pc,
  output logic [15:0]         ir,
  output logic [4*DATA_W-1:0] regfile,
  input  logic [1:0]          dbg_sel,
  output logic [DATA_W-1:0]   dbg_data,
  output logic [1:0]          flags,
  output logic                retire,
  output logic                halted
);

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpXor  = 4'h6;
  localparam logic [3:0] OpMov  = 4'h7;
  localparam logic [3:0] OpJmp  = 4'h8;
  localparam logic [3:0] OpBz   = 4'h9;
  localparam logic [3:0] OpAddi = 4'hA;
  localparam logic [3:0] OpHalt = 4'hF;

  state_e                     state_q, state_d;
  logic [PC_W-1:0]            pc_q, pc_d;
  logic [15:0]                ir_q, ir_d;
  logic [3:0][DATA_W-1:0]     rf_q, rf_d;
  logic [DATA_W-1:0]          opa_q, opa_d, opb_q, opb_d;
  logic                       carry_q, carry_d, zero_q, zero_d;

  logic [3:0]                 op;
  logic [1:0]                 rd, rs;
  logic [DATA_W-1:0]          imm_ext;
  logic [PC_W-1:0]            imm_pc, pc_inc;
  logic [DATA_W:0]            wide;
  logic [DATA_W-1:0]          res;

  assign op      = ir_q[15:12];
  assign rd      = ir_q[11:10];
  assign rs      = ir_q[9:8];
  assign imm_ext = DATA_W'(ir_q[7:0]);
  assign imm_pc  = ir_q[PC_W-1:0];
  assign pc_inc  = pc_q + PC_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    rf_d    = rf_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    wide    = '0;
    res     = '0;

    unique case (state_q)
      StFetch: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        opa_d   = rf_q[rd];
        opb_d   = rf_q[rs];
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_inc;
        case (op)
          OpLdi: rf_d[rd] = imm_ext;
          OpMov: rf_d[rd] = opb_q;
          OpAdd, OpSub, OpAddi: begin
            // Extra top bit holds carry for adds and borrow for SUB.
            if (op == OpSub)      wide = {1'b0, opa_q} - {1'b0, opb_q};
            else if (op == OpAdd) wide = {1'b0, opa_q} + {1'b0, opb_q};
            else                  wide = {1'b0, opa_q} + {1'b0, imm_ext};
            res      = wide[DATA_W-1:0];
            rf_d[rd] = res;
            carry_d  = wide[DATA_W];
            zero_d   = (res == '0);
          end
          OpAnd, OpOr, OpXor: begin
            if (op == OpAnd)     res = opa_q & opb_q;
            else if (op == OpOr) res = opa_q | opb_q;
            else                 res = opa_q ^ opb_q;
            rf_d[rd] = res;
            carry_d  = 1'b0;
            zero_d   = (res == '0);
          end
          OpJmp: pc_d = imm_pc;
          OpBz: begin
            if (opa_q == '0) pc_d = imm_pc;
          end
          OpHalt: state_d = StHalt;
          default: ; // NOP and illegal ops only advance pc
        endcase
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= PC_W'(RESET_PC);
      ir_q    <= '0;
      rf_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      rf_q    <= rf_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Request is masked by reset so the port is quiet while the core is held.
  assign imem.imem_req  = (state_q == StFetch) && reset;
  assign imem.imem_addr = pc_q;

  assign pc       = pc_q;
  assign ir       = ir_q;
  assign regfile  = rf_q;
  assign dbg_data = rf_q[dbg_sel];
  assign flags    = {carry_q, zero_q};
  assign retire   = (state_q == StExec);
  assign halted   = (state_q == StHalt);

  logic unused_op_consts;
  assign unused_op_consts = ^{OpNop};

endmodule

// File: tb/tb_mcycle_cpu.sv
// Directed and randomized programs for mcycle_cpu, checked against an instruction-level model.
module tb_mcycle_cpu;
  localparam int DW     = 8;
  localparam int PW     = 8;
  localparam int MASK   = (1 << DW) - 1;
  localparam int PCMASK = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mcycle_cpu_if #(.PC_W(PW)) imem_bus ();

  logic [PW-1:0]   pc;
  logic [15:0]     ir;
  logic [4*DW-1:0] regfile;
  logic [1:0]      dbg_sel = 2'd0;
  logic [DW-1:0]   dbg_data;
  logic [1:0]      flags;
  logic            retire;
  logic            halted;

  mcycle_cpu #(.DATA_W(DW), .PC_W(PW), .RESET_PC(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .imem     (imem_bus.master),
    .pc       (pc),
    .ir       (ir),
    .regfile  (regfile),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .flags    (flags),
    .retire   (retire),
    .halted   (halted)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [256];
  int m_r [4];
  int m_pc, m_c, m_z, m_halt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rf_of(input int i);
    return regfile[i*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_pc = 0; m_c = 0; m_z = 0; m_halt = 0;
  endtask

  // Architectural effect of one instruction, straight from the ISA table.
  task automatic model_exec(input logic [15:0] instr);
    int op, rd, rs, imm, a, b, s, npc;
    op  = int'(instr[15:12]);
    rd  = int'(instr[11:10]);
    rs  = int'(instr[9:8]);
    imm = int'(instr[7:0]);
    a   = m_r[rd];
    b   = m_r[rs];
    npc = (m_pc + 1) & PCMASK;
    case (op)
      1: m_r[rd] = imm & MASK;
      2, 10: begin
        s = a + ((op == 2) ? b : imm);
        m_c = (s >> DW) & 1; m_r[rd] = s & MASK; m_z = (m_r[rd] == 0);
      end
      3: begin
        m_c = (a < b); m_r[rd] = (a - b) & MASK; m_z = (m_r[rd] == 0);
      end
      4, 5, 6: begin
        s = (op == 4) ? (a & b) : (op == 5) ? (a | b) : (a ^ b);
        m_c = 0; m_r[rd] = s; m_z = (s == 0);
      end
      7: m_r[rd] = b;
      8: npc = imm & PCMASK;
      9: if (a == 0) npc = imm & PCMASK;
      15: m_halt = 1;
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, imem_bus.imem_req, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_regfile"}, regfile, 0);
    chk({tag, "_flags"}, flags, 0);
    chk({tag, "_retire"}, retire, 0);
    chk({tag, "_halted"}, halted, 0);
  endtask

  task automatic do_reset(input bit expect_fetching);
    @(negedge clk);
    if (expect_fetching) chk("midfetch_req", imem_bus.imem_req, 1);
    reset = 1'b0;
    imem_bus.imem_ack = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_hold");
    reset = 1'b1;
    #1;
    chk("first_fetch_req", imem_bus.imem_req, 1);
    chk("first_fetch_addr", imem_bus.imem_addr, 0);
    model_reset();
  endtask

  // Runs until HALT or max_ret retirements; wmode<0 gives random fetch waits.
  task automatic run(input int max_ret, input int wmode);
    int wl, prev, nret;
    bit pending, done;
    wl = (wmode < 0) ? int'($urandom_range(0, 3)) : wmode;
    prev = -1; nret = 0; pending = 0; done = 0;
    for (int budget = 0; budget < 3000; budget++) begin
      if (pending) begin
        chk("pc", pc, m_pc);
        for (int i = 0; i < 4; i++) chk($sformatf("r%0d", i), rf_of(i), m_r[i]);
        chk("flags", flags, {m_c[0], m_z[0]});
        chk("halted", halted, m_halt);
        chk("dbg_data", dbg_data, m_r[dbg_sel]);
        chk("next_req", imem_bus.imem_req, !m_halt);
        pending = 0;
      end
      chk("req_retire_excl", imem_bus.imem_req & retire, 0);
      if (retire) begin
        chk("ir", ir, mem[m_pc]);
        if (wmode == 0 && prev >= 0) chk("retire_gap", cyc - prev, 3);
        prev = cyc;
        model_exec(mem[m_pc]);
        nret++;
        pending = 1;
      end else if (imem_bus.imem_req) begin
        chk("fetch_addr", imem_bus.imem_addr, m_pc);
      end
      if (!pending && (m_halt != 0 || nret >= max_ret)) begin
        done = 1;
        break;
      end
      if (imem_bus.imem_req) begin
        if (wl == 0) begin
          imem_bus.imem_ack   = 1'b1;
          imem_bus.imem_rdata = mem[imem_bus.imem_addr];
          wl = (wmode < 0) ? int'($urandom_range(0, 3)) : wmode;
        end else begin
          imem_bus.imem_ack   = 1'b0;
          imem_bus.imem_rdata = 16'($urandom);
          wl--;
        end
      end else begin
        imem_bus.imem_ack   = (wmode < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_bus.imem_rdata = 16'($urandom);
      end
      dbg_sel = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    chk("run_timeout", done, 1);
    imem_bus.imem_ack = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 16'h0000;

    // Zero-wait ALU sequence with retire spacing.
    clear_mem();
    mem[0] = 16'h1405; mem[1] = 16'h1803; mem[2] = 16'h2600; mem[3] = 16'hF000;
    do_reset(0);
    run(10, 0);
    chk("add_r1", rf_of(1), 8);
    chk("add_flags", flags, 2'b00);

    // Carry/zero on 0xFF+1.
    clear_mem();
    mem[0] = 16'h10FF; mem[1] = 16'hA001; mem[2] = 16'hF000;
    do_reset(0);
    run(10, 0);
    chk("addi_r0", rf_of(0), 0);
    chk("addi_flags", flags, 2'b11);

    // Borrow on 0-1.
    clear_mem();
    mem[0] = 16'h1400; mem[1] = 16'h1801; mem[2] = 16'h3600; mem[3] = 16'hF000;
    do_reset(0);
    run(10, 0);
    chk("sub_r1", rf_of(1), 8'hFF);
    chk("sub_flags", flags, 2'b10);

    // Branch taken/not taken, JMP, and pc wrap at 0xFF.
    clear_mem();
    mem[8'h00] = 16'h9030; mem[8'h01] = 16'hF000;
    mem[8'h30] = 16'h1C00; mem[8'h31] = 16'h9C10;
    mem[8'h10] = 16'h1C02; mem[8'h11] = 16'h9C40; mem[8'h12] = 16'h1001; mem[8'h13] = 16'h80FF;
    mem[8'hFF] = 16'h0000;
    do_reset(0);
    run(20, -1);
    chk("branch_end_pc", pc, 2);

    // Four-cycle fetch stalls.
    clear_mem();
    mem[0] = 16'h1405; mem[1] = 16'h1803; mem[2] = 16'h2600; mem[3] = 16'hF000;
    do_reset(0);
    run(10, 4);
    chk("stall_r1", rf_of(1), 8);

    // HALT stays quiet, then reset mid-fetch of a new program.
    repeat (10) begin
      @(negedge clk);
      chk("halt_req", imem_bus.imem_req, 0);
      chk("halt_retire", retire, 0);
      chk("halt_halted", halted, 1);
    end
    clear_mem();
    mem[0] = 16'h1477; mem[1] = 16'h1855; mem[2] = 16'h6600;
    do_reset(0);
    run(2, 4);
    do_reset(1);

    // Random programs with random waits and stray acks.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      do_reset(0);
      run(40, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
